fir_mac: RTL
============

Name: fir_mac

Overview:
- Multiply-accumulate datapath directly downstream of the system controller.
- Holds a loadable coefficient bank and multiplies each sample word read from data memory by the coefficient selected by cidx.
- Accumulates the products into a 36-bit sum, which is returned to the controller on acc.
- Pulses sum_vld once TAPS products have been accumulated since the last clear.

Parameters:
- DW, 16: sample width, signed two's complement.
- CW, 16: coefficient width, signed two's complement.
- AW, 36: accumulator width; must be at least DW+CW.
- TAPS, 8: number of accumulated products per output sample.
- NCOEF, 16: coefficient bank depth, addressed by a 4-bit index.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous active-low reset.
- sclr, input, 1: synchronous soft clear, driven from the controller's ctrl[1].
- din, input, DW: sample word from data memory.
- cidx, input, 4: coefficient read index.
- acc_en, input, 1: the current din/cidx pair is a valid product term.
- acc_clr, input, 1: this term starts a new sum.
- coef_wr, input, 1: coefficient write strobe.
- coef_addr, input, 4: coefficient write address.
- coef_din, input, CW: coefficient write data.
- acc, output, AW: accumulated sum.
- sum_vld, output, 1: one-cycle pulse when a TAPS-term sum is complete.
- ovf, output, 1: sticky signed-overflow flag for the current sum.

Behaviour:
- Reset (rst=0, asynchronous):
  - All coefficients, pipeline registers and tags go to 0.
  - acc=0, sum_vld=0, ovf=0, tap count=0.
- Pipeline: 3 registered stages; a term presented at edge t affects acc at edge t+3.
  - S1 registers din, coef[cidx], and the tags en1=acc_en and clr1=acc_clr.
  - S2 registers the signed product p2 = s1_din * s1_coef (DW+CW bits), with tags en2 and clr2.
  - S3 updates the accumulator according to the rules below.
- S3 accumulator update:
  - clr2=1, en2=1: acc = sign-extended p2, ovf=0, count=1.
  - clr2=1, en2=0: acc=0, ovf=0, count=0.
  - clr2=0, en2=1: acc = acc + sign-extended p2, count = count+1.
  - clr2=0, en2=0: acc, ovf and count hold.
- Arithmetic: AW-bit two's complement with wrap-around.
  - ovf sets when both addends have the same sign and the result sign differs.
  - ovf stays set until the next clear, sclr or reset.
- sum_vld: high for exactly one cycle, the cycle after S3 raises count to TAPS.
  - acc holds the completed sum while sum_vld is high, and holds further until the next en2 or clr2.
  - count saturates at TAPS; further en2 terms still accumulate but do not re-pulse sum_vld.
- Coefficient bank:
  - Write on coef_wr at the rising edge.
  - A write to the same address that S1 reads in that cycle returns the old value (read-before-write).
- sclr, synchronous, highest priority over all other inputs:
  - Clears all pipeline tags and data, acc, ovf, count and sum_vld.
  - Coefficients are retained.
  - Terms already in flight are discarded.
- Reset mid-operation: same as power-on reset; coefficients must be reloaded.
- cidx values at or above NCOEF: not possible with NCOEF=16; no out-of-range handling.

Test Plan:
- Coefficient load and dot product:
  - Stimulus: load coef[0..7]=1..8; present din=1..8 with cidx=0..7, acc_en=1 each cycle, acc_clr=1 on the first term.
  - Required: acc=204 three cycles after the last term; sum_vld high exactly 1 cycle; ovf=0.
- Signed operands:
  - Stimulus: coef[0]=-3 (0xFFFD), din=0x7FFF, 1 term with clr, then 7 terms of din=0.
  - Required: acc = -98301 sign-extended (0xFFFFE8003); sum_vld pulses after the 8th term.
- Overflow:
  - Stimulus: coef=0x8000, din=0x8000 (product 2^30), 40 terms accumulated (clr on the first, TAPS raised to 64 for this test).
  - Required: ovf sets on the term that crosses 2^35-1 and acc wraps negative; the next acc_clr term sets ovf=0.
- Gaps in acc_en:
  - Stimulus: interleave acc_en=0 cycles among the 8 terms of test 1.
  - Required: same final acc=204; sum_vld is delayed by the gap count.
- sclr mid-sum:
  - Stimulus: after 4 terms, assert sclr for 1 cycle.
  - Required: next cycle acc=0 and ovf=0; in-flight terms never reach acc; no sum_vld.
  - Then: a new 8-term sum completes normally using the retained coefficients.
- Async reset and write collision:
  - Stimulus: drop rst mid-sum.
  - Required: acc, sum_vld and ovf go to 0 immediately without a clock; coefficients read back as 0.
  - Stimulus: coef_wr to address 2 with cidx=2 in the same cycle.
  - Required: the product uses the old coef[2]; the next read uses the new value.

Source files
------------

// File: rtl/fir_mac.sv
// Three-stage signed multiply-accumulate with a loadable coefficient bank.
// Products of din and coef[cidx] are summed into an AW-bit wrapping accumulator with sticky overflow.
module fir_mac #(
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int AW    = 36,
    parameter int TAPS  = 8,
    parameter int NCOEF = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclr,
    input  logic [DW-1:0] din,
    input  logic [3:0]    cidx,
    input  logic          acc_en,
    input  logic          acc_clr,
    input  logic          coef_wr,
    input  logic [3:0]    coef_addr,
    input  logic [CW-1:0] coef_din,
    output logic [AW-1:0] acc,
    output logic          sum_vld,
    output logic          ovf
);

    localparam int PW   = DW + CW;
    localparam int CNTW = $clog2(TAPS + 1);
    localparam logic [CNTW-1:0] TAPS_C = CNTW'(TAPS);
    localparam logic [CNTW-1:0] ONE_C  = CNTW'(1);

    // Wrapping add; MSB of the result flags a signed overflow.
    function automatic logic [AW:0] add_wrap(input logic signed [AW-1:0] a,
                                             input logic signed [AW-1:0] b);
        logic signed [AW-1:0] s;
        logic                 o;
        s = a + b;
        o = (a[AW-1] == b[AW-1]) && (s[AW-1] != a[AW-1]);
        return {o, s};
    endfunction

    function automatic logic signed [AW-1:0] sext_prod(input logic signed [PW-1:0] p);
        return AW'(p);
    endfunction

    logic signed [CW-1:0] coef_q [NCOEF];
    logic signed [CW-1:0] coef_d [NCOEF];

    logic signed [DW-1:0] din_p1_q, din_p1_d;
    logic signed [CW-1:0] coef_p1_q, coef_p1_d;
    logic                 vld_p1_q, vld_p1_d;
    logic                 clr_p1_q, clr_p1_d;

    logic signed [PW-1:0] prod_p2_q, prod_p2_d;
    logic                 vld_p2_q, vld_p2_d;
    logic                 clr_p2_q, clr_p2_d;

    logic signed [AW-1:0] acc_p3_q, acc_p3_d;
    logic                 ovf_q, ovf_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic                 sum_vld_q, sum_vld_d;

    logic signed [AW-1:0] prod_ext;
    logic [AW:0]          sum_ov;

    always_comb begin
        coef_d    = coef_q;
        prod_ext  = sext_prod(prod_p2_q);
        sum_ov    = add_wrap(acc_p3_q, prod_ext);

        // S1: capture operands; coef_q is read before this cycle's write lands
        din_p1_d  = din;
        coef_p1_d = coef_q[cidx];
        vld_p1_d  = acc_en;
        clr_p1_d  = acc_clr;

        // S2: full-precision signed product
        prod_p2_d = PW'(din_p1_q) * PW'(coef_p1_q);
        vld_p2_d  = vld_p1_q;
        clr_p2_d  = clr_p1_q;

        // S3: accumulate, count terms, flag completion
        acc_p3_d  = acc_p3_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        sum_vld_d = 1'b0;
        if (clr_p2_q) begin
            ovf_d = 1'b0;
            if (vld_p2_q) begin
                acc_p3_d  = prod_ext;
                cnt_d     = ONE_C;
                sum_vld_d = (TAPS == 1);
            end else begin
                acc_p3_d = '0;
                cnt_d    = '0;
            end
        end else if (vld_p2_q) begin
            acc_p3_d = sum_ov[AW-1:0];
            ovf_d    = ovf_q | sum_ov[AW];
            if (cnt_q != TAPS_C) begin
                cnt_d     = cnt_q + ONE_C;
                sum_vld_d = ((cnt_q + ONE_C) == TAPS_C);
            end
        end

        if (sclr) begin
            din_p1_d  = '0;
            coef_p1_d = '0;
            vld_p1_d  = 1'b0;
            clr_p1_d  = 1'b0;
            prod_p2_d = '0;
            vld_p2_d  = 1'b0;
            clr_p2_d  = 1'b0;
            acc_p3_d  = '0;
            ovf_d     = 1'b0;
            cnt_d     = '0;
            sum_vld_d = 1'b0;
        end else if (coef_wr) begin
            coef_d[coef_addr] = coef_din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCOEF; i++) coef_q[i] <= '0;
            din_p1_q  <= '0;
            coef_p1_q <= '0;
            vld_p1_q  <= 1'b0;
            clr_p1_q  <= 1'b0;
            prod_p2_q <= '0;
            vld_p2_q  <= 1'b0;
            clr_p2_q  <= 1'b0;
            acc_p3_q  <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            sum_vld_q <= 1'b0;
        end else begin
            coef_q    <= coef_d;
            din_p1_q  <= din_p1_d;
            coef_p1_q <= coef_p1_d;
            vld_p1_q  <= vld_p1_d;
            clr_p1_q  <= clr_p1_d;
            prod_p2_q <= prod_p2_d;
            vld_p2_q  <= vld_p2_d;
            clr_p2_q  <= clr_p2_d;
            acc_p3_q  <= acc_p3_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            sum_vld_q <= sum_vld_d;
        end
    end

    assign acc     = acc_p3_q;
    assign sum_vld = sum_vld_q;
    assign ovf     = ovf_q;

endmodule
